// File: rtl/nn_stream_pkg.sv
// rtl/nn_stream_pkg.sv - shared stream types, pool sizing and signed max helper
// for the maxpool_relu_16_2 stage.
package nn_stream_pkg;

  localparam int T          = 16;
  localparam int P          = 2;
  localparam int POOL_CNT_W = $clog2(P);

  typedef logic signed [T-1:0] data_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Ties return a, so the running maximum keeps its current value.
  function automatic data_t smax(data_t a, data_t b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/maxpool_relu_16_2_if.sv
// rtl/maxpool_relu_16_2_if.sv - input and output valid/ready streams of the
// pooling stage.
interface maxpool_relu_16_2_if;
  import nn_stream_pkg::*;

  data_t s_data_in_x;
  logic  s_valid_x;
  logic  s_ready_x;
  data_t m_data_out_y;
  logic  m_valid_y;
  logic  m_ready_y;

  modport slave (
    input  s_data_in_x, s_valid_x, m_ready_y,
    output s_ready_x, m_data_out_y, m_valid_y
  );

  modport master (
    output s_data_in_x, s_valid_x, m_ready_y,
    input  s_ready_x, m_data_out_y, m_valid_y
  );

endinterface

// File: rtl/maxpool_acc.sv
// rtl/maxpool_acc.sv - group index counter and running signed maximum;
// flags the final sample of each group.
module maxpool_acc
  import nn_stream_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  in_fire,
  input  data_t in_data,
  output logic  last,
  output logic  done,
  output data_t result
);

  localparam logic [POOL_CNT_W-1:0] CNT_LAST = POOL_CNT_W'(P - 1);

  logic [POOL_CNT_W-1:0] cnt;
  data_t                 acc;

  assign last   = (cnt == CNT_LAST);
  assign done   = in_fire && last;
  assign result = smax(acc, in_data);

  // acc only moves on an accepted sample, so idle-cycle data never reaches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
    end else if (in_fire) begin
      cnt <= last ? '0 : cnt + 1'b1;
      acc <= (cnt == '0) ? in_data : result;
    end
  end

endmodule

// File: rtl/maxpool_relu_16_2.sv
// rtl/maxpool_relu_16_2.sv - streaming signed max-pool by P with an optional
// rectified output, enabled by defining MAXPOOL_RELU_EN.
module maxpool_relu_16_2
  import nn_stream_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  maxpool_relu_16_2_if.slave  bus
);

  out_state_t state, state_nxt;
  data_t      out_q;
  data_t      load_val;
  data_t      result;
  logic       last, done, in_fire, out_fire;

  // The final sample stalls only while a result is waiting and not draining.
  assign bus.s_ready_x = !last || (state == OUT_EMPTY) || bus.m_ready_y;
  assign in_fire       = bus.s_valid_x && bus.s_ready_x;
  assign out_fire      = (state == OUT_FULL) && bus.m_ready_y;

  maxpool_acc u_acc (
    .clk     (clk),
    .reset   (reset),
    .in_fire (in_fire),
    .in_data (bus.s_data_in_x),
    .last    (last),
    .done    (done),
    .result  (result)
  );

`ifdef MAXPOOL_RELU_EN
  assign load_val = result[T-1] ? '0 : result;
`else
  assign load_val = result;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      OUT_EMPTY: if (done) state_nxt = OUT_FULL;
      OUT_FULL:  if (!done && out_fire) state_nxt = OUT_EMPTY;
      default:   state_nxt = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OUT_EMPTY;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      if (done) out_q <= load_val;
    end
  end

  assign bus.m_valid_y    = (state == OUT_FULL);
  assign bus.m_data_out_y = out_q;

endmodule

// File: tb/tb_maxpool_relu_16_2.sv
// tb/tb_maxpool_relu_16_2.sv - scoreboard bench for maxpool_relu_16_2 with a
// group-max reference model; honours MAXPOOL_RELU_EN.
module tb_maxpool_relu_16_2;

  localparam int POOL = 2;
  localparam int N_RAND = 2340;

  logic clk = 1'b0;
  logic reset;

  maxpool_relu_16_2_if bus ();

  maxpool_relu_16_2 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_in  = 0;
  int n_out = 0;

  logic signed [15:0] grp[$];
  logic signed [15:0] exp_q[$];
  logic               hold_v = 1'b0;
  logic signed [15:0] hold_d;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      grp.delete();
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        total++;
        if (!(bus.m_valid_y && bus.m_data_out_y == hold_d)) begin
          bad++;
          $display("FAIL hold actual=%0b/%0h required=1/%0h",
                   bus.m_valid_y, bus.m_data_out_y, hold_d);
        end
      end
      if (bus.m_valid_y && bus.m_ready_y) begin
        n_out++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL output actual=%0h required=none", bus.m_data_out_y);
        end else begin
          logic signed [15:0] e;
          e = exp_q.pop_front();
          if (bus.m_data_out_y !== e) begin
            bad++;
            $display("FAIL output actual=%0h required=%0h", bus.m_data_out_y, e);
          end
        end
      end
      hold_v = bus.m_valid_y && !bus.m_ready_y;
      hold_d = bus.m_data_out_y;
      if (bus.s_valid_x && bus.s_ready_x) begin
        n_in++;
        grp.push_back(bus.s_data_in_x);
        if (grp.size() == POOL) begin
          logic signed [15:0] m;
          m = grp[0];
          foreach (grp[i]) if (grp[i] > m) m = grp[i];
`ifdef MAXPOOL_RELU_EN
          if (m < 0) m = 0;
`endif
          exp_q.push_back(m);
          grp.delete();
        end
      end
    end
  end

  // Offer one sample; returns the s_ready_x seen during the offer cycle.
  task automatic put(input logic [15:0] v, input bit rdy, output bit rdy_seen);
    bus.s_data_in_x = v;
    bus.s_valid_x   = 1'b1;
    bus.m_ready_y   = rdy;
    @(negedge clk);
    rdy_seen = bus.s_ready_x;
    @(posedge clk); #1;
    bus.s_valid_x = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.s_valid_x = 1'b0;
    bus.m_ready_y = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    bit r;
    int base, cycles;

    reset = 1'b1;
    bus.s_valid_x   = 1'b0;
    bus.s_data_in_x = '0;
    bus.m_ready_y   = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_valid", int'(bus.m_valid_y), 0);
    chk("rst_data",  int'(bus.m_data_out_y), 0);
    chk("rst_ready", int'(bus.s_ready_x), 1);
    reset = 1'b0;

    // Basic pooling
    put(16'd3, 1, r);
    put(16'd7, 1, r);
    chk("lat_valid", int'(bus.m_valid_y), 1);
    put(-16'sd5, 1, r);
    put(-16'sd2, 1, r);
    idle(3);

    // Backpressure, then simultaneous drain and load
    put(16'd1, 0, r); chk("bp_rdy1", int'(r), 1);
    put(16'd9, 0, r); chk("bp_rdy2", int'(r), 1);
    put(16'd4, 0, r); chk("bp_rdy3", int'(r), 1);
    bus.s_data_in_x = 16'd2;
    bus.s_valid_x   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall", int'(bus.s_ready_x), 0);
      chk("bp_data",  int'(bus.m_data_out_y), 9);
    end
    @(posedge clk); #1;
    bus.m_ready_y = 1'b1;
    @(negedge clk);
    chk("bp_release", int'(bus.s_ready_x), 1);
    @(posedge clk); #1;
    bus.s_valid_x = 1'b0;
    @(negedge clk);
    chk("swap_valid", int'(bus.m_valid_y), 1);
    chk("swap_data",  int'(bus.m_data_out_y), 4);
    @(posedge clk); #1;
    idle(3);

    // Boundary values
    put(16'h8000, 1, r); put(16'h7FFF, 1, r);
    put(16'h8000, 1, r); put(16'h8000, 1, r);
    put(16'hFFFF, 1, r); put(16'h0000, 1, r);
    idle(3);

    // Reset mid-group
    base = n_out;
    put(16'd1, 1, r);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid_in", int'(bus.m_valid_y), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_valid_after", int'(bus.m_valid_y), 0);
    put(16'd5, 1, r);
    put(16'd6, 1, r);
    idle(3);
    chk("midrst_count", n_out - base, 1);

    // Random stress
    base   = n_out;
    cycles = 0;
    begin
      int start_in;
      start_in = n_in;
      while (cycles < 20000) begin
        @(posedge clk); #1;
        cycles++;
        if (n_in - start_in >= N_RAND) break;
        bus.s_valid_x   = 1'($urandom_range(0, 1));
        bus.s_data_in_x = 16'($urandom);
        bus.m_ready_y   = 1'($urandom_range(0, 1));
      end
      chk("rand_timeout", int'(cycles < 20000), 1);
      chk("rand_inputs", n_in - start_in, N_RAND);
    end
    idle(10);
    chk("rand_outputs", n_out - base, N_RAND / POOL);
    chk("exp_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
